m_proc_mc: RTL and testbench

- Multi-cycle RV32I-subset core; successor to the single-cycle addi-only datapath.
- Adds the following, all parametrised:
  - a fetch/decode/execute/memory/writeback FSM
  - real branches and jumps (no clamped PC)
  - word loads and stores to a local data memory
  - halt detection
  - a bench-writable instruction memory
- Sits under the simulation top; drives a0, PC and retire observability for the bench.

---
 rtl/m_proc_mc_if.sv | 16 +
 rtl/m_proc_mc.sv | 189 ++++++++++++++++++
 tb/tb_m_proc_mc.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_proc_mc_if.sv
// Instruction-load and observability bus of the multi-cycle RV32I-subset core.
interface m_proc_mc_if;
    logic        w_imem_we;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_data;
    logic [31:0] w_pc;
    logic [31:0] w_a0;
    logic        w_retire;
    logic        w_halt;
    logic        w_illegal;

    modport slave  (input  w_imem_we, w_imem_addr, w_imem_data,
                    output w_pc, w_a0, w_retire, w_halt, w_illegal);
    modport master (output w_imem_we, w_imem_addr, w_imem_data,
                    input  w_pc, w_a0, w_retire, w_halt, w_illegal);
endinterface

// File: rtl/m_proc_mc.sv
// Multi-cycle RV32I-subset core: IF/ID/EX/MEM/WB FSM, local IMEM/DMEM, halt on ECALL
// or on an undecoded instruction.
module m_proc_mc #(
    parameter int          IMEM_DEPTH = 64,
    parameter int          DMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input logic        w_clk,
    input logic        w_rst,
    m_proc_mc_if.slave bus
);
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
    localparam logic [6:0] OP_IMM = 7'h13, OP_REG = 7'h33, OP_LUI = 7'h37, OP_LOAD = 7'h03,
                           OP_STORE = 7'h23, OP_BR = 7'h63, OP_JAL = 7'h6f, OP_JALR = 7'h67;
    localparam logic [31:0] ECALL = 32'h00000073;

    logic [2:0]  r_state;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_alu, r_mdr;
    logic        r_illegal;
    logic [31:0] r_regs [32];
    logic [31:0] r_imem [IMEM_DEPTH];
    logic [31:0] r_dmem [DMEM_DEPTH];

    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic        w_f3_alu, w_legal, w_taken, w_lt, w_blt, w_unused;
    logic [31:0] w_imm, w_opb, w_alu, w_wb, w_npc;

    assign w_op  = r_ir[6:0];
    assign w_rd  = r_ir[11:7];
    assign w_f3  = r_ir[14:12];
    assign w_rs1 = r_ir[19:15];
    assign w_rs2 = r_ir[24:20];
    assign w_f7  = r_ir[31:25];
    assign w_unused = ^{bus.w_imem_addr[31:IW+2], bus.w_imem_addr[1:0]};

    // f3 in {ADD/SUB, SLT, XOR, OR, AND}
    assign w_f3_alu = (w_f3 == 3'd0) || (w_f3 == 3'd2) || (w_f3[2] && w_f3 != 3'd5);

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            OP_IMM:            w_legal = w_f3_alu;
            OP_REG:            w_legal = (w_f7 == 7'h00 && w_f3_alu) || (w_f7 == 7'h20 && w_f3 == 3'd0);
            OP_LUI, OP_JAL:    w_legal = 1'b1;
            OP_LOAD, OP_STORE: w_legal = (w_f3 == 3'd2);
            OP_BR:             w_legal = !w_f3[1];
            OP_JALR:           w_legal = (w_f3 == 3'd0);
            default:           w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
        case (w_op)
            OP_STORE: w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            OP_BR:    w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
            OP_LUI:   w_imm = {r_ir[31:12], 12'b0};
            OP_JAL:   w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
            default:  ;
        endcase
    end

    assign w_opb = (w_op == OP_REG) ? r_b : r_imm;
    assign w_lt  = $signed(r_a) < $signed(w_opb);
    assign w_blt = $signed(r_a) < $signed(r_b);

    always_comb begin
        w_alu = r_a + w_opb;
        case (w_op)
            OP_LUI:          w_alu = r_imm;
            OP_JAL, OP_JALR: w_alu = r_pc + 32'd4;
            OP_IMM, OP_REG: begin
                case (w_f3)
                    3'd0:    w_alu = (w_op == OP_REG && w_f7[5]) ? r_a - w_opb : r_a + w_opb;
                    3'd2:    w_alu = {31'b0, w_lt};
                    3'd4:    w_alu = r_a ^ w_opb;
                    3'd6:    w_alu = r_a | w_opb;
                    3'd7:    w_alu = r_a & w_opb;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_f3)
            3'd0:    w_taken = (r_a == r_b);
            3'd1:    w_taken = (r_a != r_b);
            3'd4:    w_taken = w_blt;
            3'd5:    w_taken = !w_blt;
            default: ;
        endcase
    end

    always_comb begin
        w_npc = r_pc + 32'd4;
        if (w_op == OP_JAL)
            w_npc = r_pc + r_imm;
        else if (w_op == OP_JALR)
            w_npc = (r_a + r_imm) & ~32'd1;
    end

    assign w_wb = (w_op == OP_LOAD) ? r_mdr : r_alu;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state   <= S_IF;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_illegal <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_IF: begin
                    r_ir    <= r_imem[r_pc[IW+1:2]];
                    r_state <= S_ID;
                end
                S_ID: begin
                    r_a   <= (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
                    r_b   <= (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
                    r_imm <= w_imm;
                    if (r_ir == ECALL) begin
                        r_state <= S_HALT;
                    end else if (!w_legal) begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= S_EX;
                    end
                end
                S_EX: begin
                    r_alu <= w_alu;
                    if (w_op == OP_BR) begin
                        r_pc    <= w_taken ? r_pc + r_imm : r_pc + 32'd4;
                        r_state <= S_IF;
                    end else if (w_op == OP_LOAD || w_op == OP_STORE) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (w_op == OP_LOAD) begin
                        r_mdr   <= r_dmem[r_alu[DW+1:2]];
                        r_state <= S_WB;
                    end else begin
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_IF;
                    end
                end
                S_WB: begin
                    if (w_rd != 5'd0) r_regs[w_rd] <= w_wb;
                    r_pc    <= w_npc;
                    r_state <= S_IF;
                end
                default: ;
            endcase
        end
    end

    // Memories are not reset so program and data survive a core reset.
    always_ff @(posedge w_clk) begin
        if (bus.w_imem_we)
            r_imem[bus.w_imem_addr[IW+1:2]] <= bus.w_imem_data;
        if (r_state == S_MEM && w_op == OP_STORE)
            r_dmem[r_alu[DW+1:2]] <= r_b;
    end

    assign bus.w_pc      = r_pc;
    assign bus.w_a0      = r_regs[10];
    assign bus.w_halt    = (r_state == S_HALT);
    assign bus.w_illegal = r_illegal;
    assign bus.w_retire  = (r_state == S_EX && w_op == OP_BR) ||
                           (r_state == S_MEM && w_op == OP_STORE) ||
                           (r_state == S_WB);
endmodule

// File: tb/tb_m_proc_mc.sv
// Scoreboarded bench: an instruction-level model predicts every retire, then the halt.
module tb_m_proc_mc;
    localparam logic [31:0] ECALL = 32'h00000073;

    logic w_clk = 1'b0;
    logic w_rst = 1'b0;
    m_proc_mc_if bus ();
    m_proc_mc #(.IMEM_DEPTH(64), .DMEM_DEPTH(64), .RESET_PC(32'h0))
        dut (.w_clk(w_clk), .w_rst(w_rst), .bus(bus));

    always #5 w_clk = ~w_clk;

    typedef struct { logic [31:0] pc; int cyc; logic [31:0] a0; } exp_t;
    exp_t        sb[$];
    int          n_chk = 0, n_fail = 0, n_ret = 0;
    int          cyc_abs = 0, base = 0;
    bit          running = 0, pend = 0;
    logic [31:0] pend_a0;
    logic [31:0] prog [64];
    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [64];
    int          m_halt_cyc, m_ret;
    logic [31:0] m_pc;
    bit          m_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge w_clk) cyc_abs++;

    // Monitor: every retire pops one prediction; a0 is checked once the write has landed.
    always @(negedge w_clk) begin
        exp_t e;
        if (pend) begin
            chk("a0_after_retire", bus.w_a0, pend_a0);
            pend = 0;
        end
        if (running && bus.w_retire) begin
            n_ret++;
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_retire: got retire at pc %h expected none", bus.w_pc);
            end else begin
                e = sb.pop_front();
                chk("retire_pc", bus.w_pc, e.pc);
                chk("retire_cycle", 32'(cyc_abs - base + 1), 32'(e.cyc));
                pend_a0 = e.a0;
                pend    = 1;
            end
        end
    end

    function automatic logic [31:0] e_i(int imm, int rs1, int f3, int rd, int op);
        logic [31:0] v, r1, f, d, o;
        v = imm; r1 = rs1; f = f3; d = rd; o = op;
        return {v[11:0], r1[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] e_r(int f7, int rs2, int rs1, int f3, int rd);
        logic [31:0] s, r2, r1, f, d;
        s = f7; r2 = rs2; r1 = rs1; f = f3; d = rd;
        return {s[6:0], r2[4:0], r1[4:0], f[2:0], d[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] e_s(int imm, int rs2, int rs1);
        logic [31:0] v, r2, r1;
        v = imm; r2 = rs2; r1 = rs1;
        return {v[11:5], r2[4:0], r1[4:0], 3'b010, v[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] e_b(int off, int rs2, int rs1, int f3);
        logic [31:0] v, r2, r1, f;
        v = off; r2 = rs2; r1 = rs1; f = f3;
        return {v[12], v[10:5], r2[4:0], r1[4:0], f[2:0], v[4:1], v[11], 7'h63};
    endfunction
    function automatic logic [31:0] e_j(int off, int rd);
        logic [31:0] v, d;
        v = off; d = rd;
        return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'h6f};
    endfunction
    function automatic logic [31:0] e_u(int imm20, int rd);
        logic [31:0] v, d;
        v = imm20; d = rd;
        return {v[19:0], d[4:0], 7'h37};
    endfunction

    // Instruction-set model: executes prog until ECALL/illegal, queueing each retire.
    task automatic model_run();
        logic [31:0] pc, ir, a, b, immi, imms, immb, immj, res, npc, ad;
        int cum, lat;
        bit wr, done, ill;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        pc = 32'h0; cum = 0; m_ret = 0; m_ill = 0; done = 0;
        sb.delete();
        for (int s = 0; s < 3000 && !done; s++) begin
            ir   = prog[pc[7:2]];
            a    = m_regs[ir[19:15]];
            b    = m_regs[ir[24:20]];
            immi = {{20{ir[31]}}, ir[31:20]};
            imms = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            immb = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            immj = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            npc = pc + 4; wr = 0; res = '0; lat = 4; ill = 0;
            if (ir == ECALL) begin
                done = 1;
            end else begin
                case (ir[6:0])
                    7'h13: begin
                        wr = 1;
                        case (ir[14:12])
                            3'd0: res = a + immi;
                            3'd2: res = ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0;
                            3'd4: res = a ^ immi;
                            3'd6: res = a | immi;
                            3'd7: res = a & immi;
                            default: ill = 1;
                        endcase
                    end
                    7'h33: begin
                        wr = 1;
                        if (ir[31:25] == 7'h20 && ir[14:12] == 3'd0) res = a - b;
                        else if (ir[31:25] != 7'h00) ill = 1;
                        else case (ir[14:12])
                            3'd0: res = a + b;
                            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                            3'd4: res = a ^ b;
                            3'd6: res = a | b;
                            3'd7: res = a & b;
                            default: ill = 1;
                        endcase
                    end
                    7'h37: begin wr = 1; res = {ir[31:12], 12'b0}; end
                    7'h03: begin
                        if (ir[14:12] != 3'd2) ill = 1;
                        else begin ad = a + immi; res = m_dmem[ad[7:2]]; wr = 1; lat = 5; end
                    end
                    7'h23: begin
                        if (ir[14:12] != 3'd2) ill = 1;
                        else begin ad = a + imms; m_dmem[ad[7:2]] = b; end
                    end
                    7'h63: begin
                        lat = 3;
                        case (ir[14:12])
                            3'd0: if (a == b) npc = pc + immb;
                            3'd1: if (a != b) npc = pc + immb;
                            3'd4: if ($signed(a) < $signed(b)) npc = pc + immb;
                            3'd5: if ($signed(a) >= $signed(b)) npc = pc + immb;
                            default: ill = 1;
                        endcase
                    end
                    7'h6f: begin wr = 1; res = pc + 4; npc = pc + immj; end
                    7'h67: begin
                        if (ir[14:12] != 3'd0) ill = 1;
                        else begin wr = 1; res = pc + 4; npc = (a + immi) & ~32'd1; end
                    end
                    default: ill = 1;
                endcase
                if (ill) begin
                    m_ill = 1; done = 1;
                end else begin
                    if (wr && ir[11:7] != 5'd0) m_regs[ir[11:7]] = res;
                    cum += lat;
                    m_ret++;
                    sb.push_back('{pc, cum, m_regs[10]});
                    pc = npc;
                end
            end
        end
        chk("model_terminated", {31'b0, done}, 32'd1);
        m_halt_cyc = cum + 3;
        m_pc       = pc;
    endtask

    task automatic clr();
        for (int i = 0; i < 64; i++) prog[i] = ECALL;
    endtask

    task automatic run_prog();
        bit halted = 0;
        w_rst = 1'b1;
        for (int i = 0; i < 64; i++) begin
            logic [31:0] hi;
            hi = $urandom;
            @(negedge w_clk);
            bus.w_imem_we   = 1'b1;
            bus.w_imem_addr = {hi[23:0], 6'(i), hi[25:24]};
            bus.w_imem_data = prog[i];
        end
        @(negedge w_clk);
        bus.w_imem_we = 1'b0;
        chk("rst_pc", bus.w_pc, 32'h0);
        chk("rst_halt", {31'b0, bus.w_halt}, 32'd0);
        chk("rst_illegal", {31'b0, bus.w_illegal}, 32'd0);
        chk("rst_retire", {31'b0, bus.w_retire}, 32'd0);
        chk("rst_a0", bus.w_a0, 32'd0);
        model_run();
        n_ret   = 0;
        base    = cyc_abs;
        running = 1;
        w_rst   = 1'b0;
        for (int k = 0; k < m_halt_cyc + 40 && !halted; k++) begin
            @(negedge w_clk);
            if (bus.w_halt) halted = 1;
        end
        chk("halt_reached", {31'b0, halted}, 32'd1);
        chk("halt_cycle", 32'(cyc_abs - base + 1), 32'(m_halt_cyc));
        chk("halt_illegal", {31'b0, bus.w_illegal}, {31'b0, m_ill});
        chk("halt_pc", bus.w_pc, m_pc);
        chk("halt_a0", bus.w_a0, m_regs[10]);
        repeat (3) @(negedge w_clk);
        chk("halt_pc_frozen", bus.w_pc, m_pc);
        chk("halt_stays", {31'b0, bus.w_halt}, 32'd1);
        chk("retire_count", 32'(n_ret), 32'(m_ret));
        chk("queue_drained", 32'(sb.size()), 32'd0);
        running = 0;
        // Reset asserted between clock edges must clear the core at once.
        #2 w_rst = 1'b1;
        #1;
        chk("async_rst_halt", {31'b0, bus.w_halt}, 32'd0);
        chk("async_rst_illegal", {31'b0, bus.w_illegal}, 32'd0);
        chk("async_rst_pc", bus.w_pc, 32'h0);
        chk("async_rst_a0", bus.w_a0, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        int fi[5] = '{0, 2, 4, 6, 7};
        int bt[4] = '{0, 1, 4, 5};
        int bad[3] = '{1, 3, 5};
        int kind, rd, rs1, rs2, imm, sel;
        kind = $urandom_range(0, 10);
        rd   = ($urandom_range(0, 3) == 0) ? 10 : $urandom_range(0, 15);
        rs1  = $urandom_range(0, 15);
        rs2  = $urandom_range(0, 15);
        imm  = $urandom_range(0, 4095);
        sel  = $urandom_range(0, 5);
        case (kind)
            0, 1, 2: return e_i(imm, rs1, fi[sel % 5], rd, 7'h13);
            3, 4:    return (sel == 5) ? e_r(32, rs2, rs1, 0, rd) : e_r(0, rs2, rs1, fi[sel], rd);
            5:       return e_u($urandom_range(0, 1048575), rd);
            6:       return e_i(imm, rs1, 2, rd, 7'h03);
            7:       return e_s(imm, rs2, rs1);
            8:       return e_b(4 * $urandom_range(1, 4), rs2, rs1, bt[sel % 4]);
            9:       return e_j(4 * $urandom_range(1, 4), rd);
            default: return ($urandom_range(0, 3) == 0) ? e_i(imm, rs1, bad[sel % 3], rd, 7'h13)
                                                        : e_i(imm, rs1, 0, rd, 7'h13);
        endcase
    endfunction

    initial begin
        bus.w_imem_we = 1'b0; bus.w_imem_addr = '0; bus.w_imem_data = '0;
        for (int i = 0; i < 64; i++) m_dmem[i] = '0;
        #1 w_rst = 1'b1;
        // Zero every DMEM word so later loads have a known model value.
        clr();
        prog[0] = e_i(0, 0, 0, 1, 7'h13);
        prog[1] = e_s(0, 0, 1);
        prog[2] = e_i(4, 1, 0, 1, 7'h13);
        prog[3] = e_i(-256, 1, 0, 2, 7'h13);
        prog[4] = e_b(-12, 0, 2, 1);
        run_prog();
        clr();
        prog[0] = e_i(3, 0, 0, 1, 7'h13); prog[1] = e_i(4, 1, 0, 2, 7'h13); prog[2] = e_i(5, 2, 0, 10, 7'h13);
        run_prog();
        clr();
        prog[0] = e_i(5, 0, 0, 1, 7'h13); prog[1] = e_i(2, 10, 0, 10, 7'h13);
        prog[2] = e_i(-1, 1, 0, 1, 7'h13); prog[3] = e_b(-8, 0, 1, 1);
        run_prog();
        clr();
        prog[0] = e_i(-7, 0, 0, 5, 7'h13); prog[1] = e_s(8, 5, 0); prog[2] = e_i(8, 0, 2, 10, 7'h03);
        run_prog();
        clr();
        prog[0] = e_j(8, 1); prog[1] = e_i(1, 0, 0, 10, 7'h13); prog[2] = e_i(0, 1, 0, 10, 7'h13);
        run_prog();
        clr();
        prog[0] = 32'hFFFFFFFF;
        run_prog();
        clr();
        prog[0] = e_i(7, 0, 0, 10, 7'h13); prog[1] = 32'hFFFFFFFF;
        run_prog();
        clr();
        prog[0] = e_i(9, 0, 0, 0, 7'h13); prog[1] = e_r(0, 0, 0, 0, 10);
        run_prog();
        clr();
        prog[0] = e_i(13, 0, 0, 5, 7'h13); prog[1] = e_i(0, 5, 0, 1, 7'h67);
        prog[2] = e_i(99, 0, 0, 10, 7'h13); prog[3] = e_i(0, 1, 0, 10, 7'h13);
        run_prog();
        clr();
        prog[0] = e_j(260, 1); prog[1] = e_i(0, 1, 0, 10, 7'h13);
        run_prog();
        for (int t = 0; t < 10; t++) begin
            clr();
            for (int i = 0; i < 24; i++) prog[i] = rand_instr();
            run_prog();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
